// File: rtl/fifo_rd_packer.sv
// Pops DSIZE-wide entries from a FIFO read port and packs them, lane 0 first,
// into LANES-wide output words; flush emits a partially filled word.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int LANES = 4
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     rempty,
  input  logic [DSIZE-1:0]         rdata,
  output logic                     rinc,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DSIZE*LANES-1:0]   m_data,
  output logic [LANES-1:0]         m_keep,
  output logic [15:0]              word_cnt,
  output logic                     dbg_state
);

  // Output handshake: a word transfers on any rising edge where m_valid and
  // m_ready are both 1; m_data/m_keep hold stable while m_valid waits for m_ready.

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_e;

  localparam int LW = $clog2(LANES + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_e                   state_q;
  logic [LW-1:0]            lane_cnt_q;
  logic [DSIZE*LANES-1:0]   data_q;
  logic [LANES-1:0]         keep_q;
  logic [15:0]              word_cnt_q;
  logic                     pop;

  // Reset gates the pop so no FIFO entry is lost while the packer is held.
  assign pop  = (state_q == COLLECT) && !rempty && !rrst;
  assign rinc = pop;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= COLLECT;
      lane_cnt_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (pop) begin
            for (int i = 0; i < LANES; i++) begin
              if (lane_cnt_q == LW'(i)) begin
                data_q[i*DSIZE +: DSIZE] <= rdata;
                keep_q[i]                <= 1'b1;
              end
            end
            lane_cnt_q <= lane_cnt_q + LW'(1);
            if (flush || (lane_cnt_q == LAST_LANE)) begin
              state_q <= OUT;
            end
          end else if (flush && (lane_cnt_q != '0)) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            lane_cnt_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            state_q    <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign m_valid   = (state_q == OUT);
  assign m_data    = data_q;
  assign m_keep    = keep_q;
  assign word_cnt  = word_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FIFO read side and an
// expected-word queue holds the hand-computed packed words.
module tb_fifo_rd_packer;

  logic        rclk;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] word_cnt;
  logic        dbg_state;

  fifo_rd_packer #(.DSIZE(8), .LANES(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model and scoreboard ----------------
  logic [7:0]  fifo_q[$];
  logic [35:0] exp_q[$];
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          pop_cnt   = 0;

  function automatic void fifo_refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endfunction

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_refresh();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic tick();
    logic p;
    #1 p = rinc;
    @(posedge rclk);
    #1;
    if (p) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_refresh();
    @(negedge rclk);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_word(input logic [3:0] keep, input logic [31:0] data);
    exp_q.push_back({keep, data});
  endtask

  task automatic check_word(input string tag);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(m_valid), 64'd1);
      check({tag, "_data"},  64'(m_data),  64'(e[31:0]));
      check({tag, "_keep"},  64'(m_keep),  64'(e[35:32]));
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int pc;
    logic [31:0] held;

    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_refresh();
    @(negedge rclk);

    // Reset with a non-empty FIFO: nothing may be consumed.
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
    tick(); tick();
    check("rst_rinc",     64'(rinc),      64'd0);
    check("rst_valid",    64'(m_valid),   64'd0);
    check("rst_data",     64'(m_data),    64'd0);
    check("rst_keep",     64'(m_keep),    64'd0);
    check("rst_wcnt",     64'(word_cnt),  64'd0);
    check("rst_state",    64'(dbg_state), 64'd0);
    check("rst_pops",     64'(pop_cnt),   64'd0);

    // Full word with m_ready held high.
    rrst    = 1'b0;
    m_ready = 1'b1;
    expect_word(4'hF, 32'h44332211);
    wait_valid(10, n);
    check("full_latency", 64'(n),       64'd4);
    check("full_pops",    64'(pop_cnt), 64'd4);
    check_word("full");
    check("full_state",   64'(dbg_state), 64'd1);
    tick();
    check("full_drop",    64'(m_valid),  64'd0);
    check("full_wcnt",    64'(word_cnt), 64'd1);

    // Back-to-back words: one word per LANES+1 cycles.
    for (int i = 1; i <= 8; i++) fifo_push(8'(i));
    expect_word(4'hF, 32'h04030201);
    expect_word(4'hF, 32'h08070605);
    wait_valid(10, n);
    check_word("tp0");
    tick();
    check("tp_gap",       64'(m_valid), 64'd0);
    wait_valid(10, n);
    check("tp_period",    64'(n + 1),   64'd5);
    check_word("tp1");
    tick();
    check("tp_wcnt",      64'(word_cnt), 64'd3);

    // Backpressure with an extra entry waiting in the FIFO.
    m_ready = 1'b0;
    fifo_push(8'h55); fifo_push(8'h66); fifo_push(8'h77); fifo_push(8'h88); fifo_push(8'h99);
    expect_word(4'hF, 32'h88776655);
    wait_valid(10, n);
    check_word("bp");
    held = m_data;
    pc   = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",   64'(m_valid), 64'd1);
      check("bp_stable",  64'(m_data),  64'(held));
      check("bp_rinc",    64'(rinc),    64'd0);
    end
    check("bp_pops",      64'(pop_cnt), 64'(pc));
    m_ready = 1'b1;
    tick();
    check("bp_done",      64'(m_valid),  64'd0);
    check("bp_wcnt",      64'(word_cnt), 64'd4);

    // Leftover entry popped together with flush: single-lane word.
    flush = 1'b1;
    expect_word(4'h1, 32'h00000099);
    tick();
    flush = 1'b0;
    check_word("one");
    tick();
    check("one_wcnt",     64'(word_cnt), 64'd5);

    // Partial flush after two pops and an empty FIFO.
    m_ready = 1'b0;
    fifo_push(8'hAA); fifo_push(8'hBB);
    tick(); tick();
    check("pf_rinc",      64'(rinc),    64'd0);
    check("pf_novalid",   64'(m_valid), 64'd0);
    flush = 1'b1;
    expect_word(4'h3, 32'h0000BBAA);
    tick();
    check_word("pf");
    flush   = 1'b0;
    m_ready = 1'b1;
    tick();
    check("pf_wcnt",      64'(word_cnt), 64'd6);

    // Flush with nothing collected is ignored.
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ef_valid",   64'(m_valid), 64'd0);
    end
    flush = 1'b0;
    check("ef_wcnt",      64'(word_cnt), 64'd6);

    // Flush in the same cycle as the third pop.
    fifo_push(8'h01); fifo_push(8'h02);
    tick(); tick();
    fifo_push(8'hCC);
    flush = 1'b1;
    expect_word(4'h7, 32'h00CC0201);
    tick();
    flush = 1'b0;
    check_word("sim");
    tick();
    check("sim_wcnt",     64'(word_cnt), 64'd7);

    // Empty FIFO mid-word stalls collection.
    fifo_push(8'h10); fifo_push(8'h20);
    tick(); tick();
    pc = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_rinc",    64'(rinc),    64'd0);
      check("st_valid",   64'(m_valid), 64'd0);
    end
    check("st_pops",      64'(pop_cnt), 64'(pc));
    fifo_push(8'h30); fifo_push(8'h40);
    expect_word(4'hF, 32'h40302010);
    wait_valid(10, n);
    check("st_latency",   64'(n), 64'd2);
    check_word("st");
    tick();
    check("st_wcnt",      64'(word_cnt), 64'd8);

    // Reset after two pops discards the partial word.
    fifo_push(8'hA1); fifo_push(8'hA2);
    tick(); tick();
    pc = pop_cnt;
    fifo_push(8'hB1); fifo_push(8'hB2); fifo_push(8'hB3); fifo_push(8'hB4);
    rrst = 1'b1;
    #1;
    check("mr_rinc",      64'(rinc), 64'd0);
    tick(); tick();
    check("mr_rinc_hold", 64'(rinc),     64'd0);
    check("mr_valid",     64'(m_valid),  64'd0);
    check("mr_keep",      64'(m_keep),   64'd0);
    check("mr_wcnt",      64'(word_cnt), 64'd0);
    check("mr_pops",      64'(pop_cnt),  64'(pc));
    rrst = 1'b0;
    expect_word(4'hF, 32'hB4B3B2B1);
    wait_valid(10, n);
    check("mr_latency",   64'(n), 64'd4);
    check_word("mr");
    tick();
    check("mr_wcnt_post", 64'(word_cnt), 64'd1);

    // Counter wrap: preload the count register near its top.
    dut.word_cnt_q = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      fifo_push(8'hE0 + 8'(i));
      flush = 1'b1;
      expect_word(4'h1, 32'h000000E0 + 32'(i));
      tick();
      flush = 1'b0;
      check_word("wr");
      tick();
      check("wr_wcnt",    64'(word_cnt), 64'(16'(16'hFFFF + 16'(i))));
    end

    check("sb_drained",   64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the FIFO read-data width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of DSIZE lanes per output word (LANES >= 2).
REQ-003 The block SHALL have port rclk  input  1  read-domain clock; all logic is rising-edge rclk.
REQ-004 The block SHALL have port rrst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port rempty  input  1  FIFO empty flag.
REQ-006 The block SHALL have port rdata  input  DSIZE  FIFO head data, valid whenever rempty=0.
REQ-007 The block SHALL have port rinc  output  1  FIFO pop strobe.
REQ-008 The block SHALL have port flush  input  1  level request to emit a partial word.
REQ-009 The block SHALL have port m_valid  output  1  output word valid.
REQ-010 The block SHALL have port m_ready  input  1  downstream accept.
REQ-011 The block SHALL have port m_data  output  DSIZE*LANES  packed word, lane 0 in the LSBs.
REQ-012 The block SHALL have port m_keep  output  LANES  per-lane valid mask.
REQ-013 The block SHALL have port word_cnt  output  16  count of words accepted downstream.

Function
REQ-014 The FSM SHALL have exactly two states: COLLECT (gathering lanes) and OUT (presenting a word).
REQ-015 rinc SHALL be combinational: rinc = (state==COLLECT) && !rempty && !rrst.
REQ-016 A pop is the cycle rinc=1; rdata SHALL be captured on that same rclk edge into lane lane_cnt, then lane_cnt increments.
REQ-017 Lanes SHALL fill in ascending order from lane 0; unfilled lanes of m_data SHALL be zero.
REQ-018 When a pop fills lane LANES-1, the FSM SHALL enter OUT on the next edge with m_valid=1 and m_keep all ones.
REQ-019 In COLLECT, flush=1 with lane_cnt>0, or with a pop this cycle, SHALL enter OUT with m_keep = ones for filled lanes only (a same-cycle pop is included).
REQ-020 In COLLECT, flush=1 with lane_cnt=0 and no pop SHALL be ignored; no empty word is ever emitted.
REQ-021 In OUT, rinc SHALL be 0 and flush SHALL be ignored.
REQ-022 In OUT, m_data and m_keep SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 In OUT, m_ready=1 SHALL complete the transfer, increment word_cnt, clear lane_cnt and the lane registers, and return to COLLECT on the next edge, with m_valid=0 in that cycle.
REQ-024 word_cnt SHALL wrap from 16'hFFFF to 0.
REQ-025 m_valid SHALL be 0 in COLLECT; m_ready in COLLECT SHALL have no effect.
REQ-026 Full-word throughput SHALL be one word per LANES+1 cycles when the FIFO is never empty and m_ready is held at 1.
REQ-027 rempty rising mid-word SHALL stall collection with no pop and no state change until rempty=0 or flush.

Reset
REQ-028 While rrst=1 at a rising edge: state=COLLECT, lane_cnt=0, and lane registers, m_data, m_keep, m_valid and word_cnt all 0.
REQ-029 rinc SHALL be 0 in any cycle with rrst=1, so no FIFO entry is consumed during reset.
REQ-030 Reset mid-word or in OUT SHALL discard the partial or pending word without emitting it.

Verification
REQ-031 Full word: FIFO holds 11,22,33,44 with m_ready=1 -> 4 pops on consecutive cycles, then m_data=32'h44332211, m_keep=4'hF for 1 cycle, word_cnt=1.
REQ-032 Backpressure: same stimulus with m_ready=0 for 5 cycles -> m_valid held, data stable, rinc=0; transfer completes on the first m_ready=1.
REQ-033 Partial flush: pop AA, BB, then rempty=1 and flush=1 -> m_data=32'h0000BBAA, m_keep=4'h3; flush with lane_cnt=0 and no pop -> no m_valid.
REQ-034 Simultaneous flush and pop: pop CC on the cycle flush=1, lane_cnt=2 -> m_keep=4'h7, lane 2=CC.
REQ-035 Reset mid-word: rrst=1 after 2 pops -> no word emitted, rinc=0 during reset; the next 4 pops form a fresh word starting at lane 0.
REQ-036 Wrap: preload word_cnt path with 65536 transfers -> word_cnt returns to 0.
